decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined successor to the combinational MIPS control decoder.
- Accepts instruction and PC from fetch over a valid/ready handshake, decodes opcode/funct into the control bundle, and registers it with operand fields for execute. Decode latency is 1 cycle.
- Adds load-use interlock, flush on taken branch/jump, illegal-instruction flagging, and a parametrised PC width and load-use gap.

Parameters:
- PC_W, 32, width of PC and jump-target fields.
- LOAD_USE_GAP, 1, cycles an LW destination stays hazardous after issue. 0 disables the interlock.
- RA_REG, 31, register index written by JAL.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard held and incoming instruction (taken branch/jump)
- in_valid  in  1  fetch presents instr/pc
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  address of in_instr
- ex_valid  out  1  output bundle valid
- ex_ready  in  1  execute consumes bundle
- ex_pc  out  PC_W  registered PC
- ex_rs, ex_rt  out  5  source register indices
- ex_wa  out  5  resolved write address: rt, rd or RA_REG
- ex_imm  out  32  sign-extended imm; zero-extended for XORI
- ex_target  out  PC_W  {pc+4 upper bits, instr[25:0], 2'b00}
- ex_alu_op  out  3  0 add, 1 sub, 2 xor, 3 slt
- ex_use_rt  out  1  ALU operand B from rt (1) or imm (0)
- ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_jump, ex_jump_link, ex_jump_reg, ex_branch, ex_bne  out  1 each  control
- ex_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset: every ex_* output is 0, hazard counter is 0, and in_ready is 0 during the reset cycle.
- Supported set:
  - LW, SW, J, JAL, BEQ, BNE, XORI, ADDI, ADDIU.
  - R-type (op 0): ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x08.
  - Control values match the existing decoder. ADDI and ADDIU both use alu_op add.
- Illegal instruction:
  - ex_illegal=1.
  - reg_write, mem_write, jump*, branch all 0; remaining fields are don't-care.
- Writes to register 0: ex_wa=0 still forces ex_reg_write=0.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (!ex_valid || ex_ready) && !stall.
  - The bundle registers on accept, and ex_valid rises the next cycle.
  - ex_valid clears when ex_ready is high and no new accept occurs.
  - The bundle holds stable while ex_valid && !ex_ready.
- Source-read rules:
  - rs is read by every type except J and JAL.
  - rt is read by SW, BEQ, BNE, ADD, SUB and SLT.
- Hazard tracking:
  - haz_cnt (width clog2(LOAD_USE_GAP+1)) and haz_reg (5 bits).
  - Accepting an LW with rt≠0 loads haz_cnt=LOAD_USE_GAP and haz_reg=rt.
  - Otherwise haz_cnt decrements (saturating at 0) each cycle ex_ready=1.
- Stall condition: stall = in_valid && haz_cnt≠0 && incoming instruction reads haz_reg.
  - During a stall, ex_valid drops after the current bundle is consumed, i.e. a bubble is issued.
- Flush (priority above everything except reset):
  - Next cycle ex_valid=0 and haz_cnt=0.
  - in_ready=1 and any incoming instr is dropped without decode.
- Simultaneous events:
  - flush together with an accept: the flush wins.
  - LW accept while haz_cnt≠0: the counter reloads.
- Reset mid-handshake drops the held bundle.
- LOAD_USE_GAP=0: stall is constant 0.

Test Plan:
1. Reset for 2 cycles, then release -> all ex_* = 0. Next cycle in_ready=1.
2. pc=0x100, in_instr=0x0C000010 (JAL) with ex_ready=1 -> next cycle:
   - ex_valid=1, ex_jump=1, ex_jump_link=1, ex_reg_write=1
   - ex_wa=31, ex_target=0x00000040, ex_pc=0x100
3. 0x8E080000 (lw $8,0($16)) followed by 0x010A4820 (add $9,$8,$10), ex_ready=1, GAP=1:
   - LW issues.
   - in_ready=0 for 1 cycle and ex_valid=0 for 1 cycle (bubble).
   - ADD then issues with ex_alu_op=0, ex_wa=9, ex_use_rt=1.
4. 0x3908FFFF (xori $8,$8,0xFFFF) -> ex_imm=0x0000FFFF, ex_alu_op=2, ex_wa=8, ex_use_rt=0.
5. Hold ex_ready=0 for 3 cycles with a bundle valid and in_valid=1:
   - Bundle stays stable and in_ready=0.
   - Raise ex_ready -> the next instruction registers the following cycle.
6. Two cases:
   - Assert flush with an LW pending and a dependent ADD at input -> ex_valid=0 next cycle, haz_cnt=0, and the ADD is dropped without stall.
   - 0xFC000000 -> ex_illegal=1, ex_reg_write=0, ex_mem_write=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake and bundle signals between fetch, decode and execute.
// Fetch side drives in_*, execute side drives ex_ready.
interface decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            ex_valid;
  logic            ex_ready;
  logic [PC_W-1:0] ex_pc;
  logic [4:0]      ex_rs;
  logic [4:0]      ex_rt;
  logic [4:0]      ex_wa;
  logic [31:0]     ex_imm;
  logic [PC_W-1:0] ex_target;
  logic [2:0]      ex_alu_op;
  logic            ex_use_rt;
  logic            ex_reg_write;
  logic            ex_mem_write;
  logic            ex_mem_to_reg;
  logic            ex_jump;
  logic            ex_jump_link;
  logic            ex_jump_reg;
  logic            ex_branch;
  logic            ex_bne;
  logic            ex_illegal;

  modport master (
    output in_valid, in_instr, in_pc, ex_ready,
    input  in_ready, ex_valid, ex_pc, ex_rs, ex_rt,
    input  ex_wa, ex_imm, ex_target, ex_alu_op,
    input  ex_use_rt, ex_reg_write, ex_mem_write,
    input  ex_mem_to_reg, ex_jump, ex_jump_link,
    input  ex_jump_reg, ex_branch, ex_bne, ex_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, ex_ready,
    output in_ready, ex_valid, ex_pc, ex_rs, ex_rt,
    output ex_wa, ex_imm, ex_target, ex_alu_op,
    output ex_use_rt, ex_reg_write, ex_mem_write,
    output ex_mem_to_reg, ex_jump, ex_jump_link,
    output ex_jump_reg, ex_branch, ex_bne, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: registered control bundle,
// load-use interlock, flush and illegal flagging.
module decode_stage #(
  parameter int PC_W         = 32,
  parameter int LOAD_USE_GAP = 1,
  parameter int RA_REG       = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  decode_stage_if.slave io
);
  localparam int HW =
    (LOAD_USE_GAP > 0) ? $clog2(LOAD_USE_GAP + 1) : 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      wa;
    logic [31:0]     imm;
    logic [PC_W-1:0] target;
    logic [2:0]      alu_op;
    logic            use_rt;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
    logic            jump;
    logic            jump_link;
    logic            jump_reg;
    logic            branch;
    logic            bne;
    logic            illegal;
  } id_ex_t;

  id_ex_t          dec;
  id_ex_t          ex_d, ex_q;
  logic            ex_valid_d, ex_valid_q;
  logic [HW-1:0]   haz_cnt_d, haz_cnt_q;
  logic [4:0]      haz_reg_d, haz_reg_q;

  logic [5:0]      op, fn;
  logic [4:0]      rs, rt, rd;
  logic [PC_W-1:0] pc4;
  logic            rd_rs, rd_rt;
  logic            stall, accept, in_ready;

  logic is_r, is_lw, is_sw, is_j, is_jal;
  logic is_beq, is_bne, is_xori, is_addi, is_addiu;
  logic is_add, is_sub, is_slt, is_jr;

  assign op  = io.in_instr[31:26];
  assign rs  = io.in_instr[25:21];
  assign rt  = io.in_instr[20:16];
  assign rd  = io.in_instr[15:11];
  assign fn  = io.in_instr[5:0];
  assign pc4 = io.in_pc + PC_W'(4);

  assign is_r     = op == 6'h00;
  assign is_lw    = op == 6'h23;
  assign is_sw    = op == 6'h2b;
  assign is_j     = op == 6'h02;
  assign is_jal   = op == 6'h03;
  assign is_beq   = op == 6'h04;
  assign is_bne   = op == 6'h05;
  assign is_xori  = op == 6'h0e;
  assign is_addi  = op == 6'h08;
  assign is_addiu = op == 6'h09;
  assign is_add   = is_r && fn == 6'h20;
  assign is_sub   = is_r && fn == 6'h22;
  assign is_slt   = is_r && fn == 6'h2a;
  assign is_jr    = is_r && fn == 6'h08;

  always_comb begin
    dec        = '0;
    dec.pc     = io.in_pc;
    dec.rs     = rs;
    dec.rt     = rt;
    dec.wa     = rt;
    dec.imm    = {{16{io.in_instr[15]}}, io.in_instr[15:0]};
    dec.target = (pc4 & ~PC_W'(28'hFFF_FFFF))
               | PC_W'({io.in_instr[25:0], 2'b00});
    rd_rs      = 1'b1;
    rd_rt      = 1'b0;
    unique case (1'b1)
      is_lw: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      is_sw: begin
        dec.mem_write = 1'b1;
        rd_rt         = 1'b1;
      end
      is_j: begin
        dec.jump = 1'b1;
        rd_rs    = 1'b0;
      end
      is_jal: begin
        dec.jump      = 1'b1;
        dec.jump_link = 1'b1;
        dec.reg_write = 1'b1;
        dec.wa        = 5'(RA_REG);
        rd_rs         = 1'b0;
      end
      is_beq, is_bne: begin
        dec.branch = 1'b1;
        dec.bne    = is_bne;
        dec.alu_op = 3'd1;
        dec.use_rt = 1'b1;
        rd_rt      = 1'b1;
      end
      is_xori: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 3'd2;
        dec.imm       = {16'h0, io.in_instr[15:0]};
      end
      is_addi, is_addiu: begin
        dec.reg_write = 1'b1;
      end
      is_add, is_sub, is_slt: begin
        dec.reg_write = 1'b1;
        dec.use_rt    = 1'b1;
        dec.wa        = rd;
        dec.alu_op    = is_sub ? 3'd1 : is_slt ? 3'd3 : 3'd0;
        rd_rt         = 1'b1;
      end
      is_jr: begin
        dec.jump_reg = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    // $0 is hardwired, so a write there is suppressed
    if (dec.wa == 5'd0)
      dec.reg_write = 1'b0;
  end

  assign stall = (LOAD_USE_GAP != 0) && io.in_valid
              && (haz_cnt_q != '0)
              && ((rd_rs && rs == haz_reg_q)
               || (rd_rt && rt == haz_reg_q));

  always_comb begin
    in_ready = 1'b0;
    if (reset)
      in_ready = 1'b0;
    else if (flush)
      in_ready = 1'b1;
    else
      in_ready = (!ex_valid_q || io.ex_ready) && !stall;
  end

  assign accept = io.in_valid && in_ready && !flush && !reset;

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    haz_cnt_d  = haz_cnt_q;
    haz_reg_d  = haz_reg_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      haz_cnt_d  = '0;
    end else begin
      if (accept) begin
        ex_d       = dec;
        ex_valid_d = 1'b1;
      end else if (io.ex_ready) begin
        ex_valid_d = 1'b0;
      end
      if (accept && is_lw && rt != 5'd0) begin
        haz_cnt_d = HW'(LOAD_USE_GAP);
        haz_reg_d = rt;
      end else if (io.ex_ready && haz_cnt_q != '0) begin
        haz_cnt_d = haz_cnt_q - HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      haz_cnt_q  <= '0;
      haz_reg_q  <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      haz_cnt_q  <= haz_cnt_d;
      haz_reg_q  <= haz_reg_d;
    end
  end

  assign io.in_ready      = in_ready;
  assign io.ex_valid      = ex_valid_q;
  assign io.ex_pc         = ex_q.pc;
  assign io.ex_rs         = ex_q.rs;
  assign io.ex_rt         = ex_q.rt;
  assign io.ex_wa         = ex_q.wa;
  assign io.ex_imm        = ex_q.imm;
  assign io.ex_target     = ex_q.target;
  assign io.ex_alu_op     = ex_q.alu_op;
  assign io.ex_use_rt     = ex_q.use_rt;
  assign io.ex_reg_write  = ex_q.reg_write;
  assign io.ex_mem_write  = ex_q.mem_write;
  assign io.ex_mem_to_reg = ex_q.mem_to_reg;
  assign io.ex_jump       = ex_q.jump;
  assign io.ex_jump_link  = ex_q.jump_link;
  assign io.ex_jump_reg   = ex_q.jump_reg;
  assign io.ex_branch     = ex_q.branch;
  assign io.ex_bne        = ex_q.bne;
  assign io.ex_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios, then random
// traffic against a mnemonic-level reference model.
module tb_decode_stage;
  localparam int GAP = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    logic [31:0] imm;
    logic [31:0] target;
    logic [2:0]  alu;
    logic        use_rt;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        j;
    logic        jl;
    logic        jr;
    logic        br;
    logic        bne;
    logic        ill;
  } bundle_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_chk = 0;
  int   n_err = 0;

  logic        m_valid;
  bundle_t     m_b;
  int          m_haz;
  logic [4:0]  m_hreg;
  logic        rdy_s;

  decode_stage_if #(.PC_W(32)) bus ();

  decode_stage #(
    .PC_W(32),
    .LOAD_USE_GAP(GAP),
    .RA_REG(31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .io(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic string mnem(input logic [31:0] i);
    case (i[31:26])
      6'h00:
        case (i[5:0])
          6'h20: return "add";
          6'h22: return "sub";
          6'h2a: return "slt";
          6'h08: return "jr";
          default: return "ill";
        endcase
      6'h23: return "lw";
      6'h2b: return "sw";
      6'h02: return "j";
      6'h03: return "jal";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h0e: return "xori";
      6'h08: return "addi";
      6'h09: return "addiu";
      default: return "ill";
    endcase
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] i,
                                         input logic [31:0] pc);
    bundle_t b;
    string m;
    logic [31:0] pc4;
    m = mnem(i);
    pc4 = pc + 32'd4;
    b = '0;
    b.pc = pc;
    b.rs = i[25:21];
    b.rt = i[20:16];
    b.wa = i[20:16];
    b.imm = 32'($signed(i[15:0]));
    b.target = {pc4[31:28], i[25:0], 2'b00};
    case (m)
      "lw":    begin b.rw = 1; b.m2r = 1; end
      "sw":    b.mw = 1;
      "j":     b.j = 1;
      "jal":   begin b.j = 1; b.jl = 1; b.rw = 1; b.wa = 5'd31; end
      "beq":   begin b.br = 1; b.alu = 1; b.use_rt = 1; end
      "bne":   begin b.br = 1; b.bne = 1; b.alu = 1; b.use_rt = 1; end
      "xori":  begin b.rw = 1; b.alu = 2; b.imm = {16'h0, i[15:0]}; end
      "addi":  b.rw = 1;
      "addiu": b.rw = 1;
      "add":   begin b.rw = 1; b.use_rt = 1; b.wa = i[15:11]; end
      "sub":   begin b.rw = 1; b.use_rt = 1; b.wa = i[15:11]; b.alu = 1; end
      "slt":   begin b.rw = 1; b.use_rt = 1; b.wa = i[15:11]; b.alu = 3; end
      "jr":    b.jr = 1;
      default: b.ill = 1;
    endcase
    if (b.wa == 5'd0) b.rw = 0;
    return b;
  endfunction

  function automatic logic reads(input logic [31:0] i,
                                 input logic [4:0] r);
    string m;
    logic  a, b;
    m = mnem(i);
    a = !(m == "j" || m == "jal");
    b = m == "sw" || m == "beq" || m == "bne"
     || m == "add" || m == "sub" || m == "slt";
    return (a && i[25:21] == r) || (b && i[20:16] == r);
  endfunction

  function automatic bundle_t obs();
    bundle_t o;
    o.pc = bus.ex_pc;
    o.rs = bus.ex_rs;
    o.rt = bus.ex_rt;
    o.wa = bus.ex_wa;
    o.imm = bus.ex_imm;
    o.target = bus.ex_target;
    o.alu = bus.ex_alu_op;
    o.use_rt = bus.ex_use_rt;
    o.rw = bus.ex_reg_write;
    o.mw = bus.ex_mem_write;
    o.m2r = bus.ex_mem_to_reg;
    o.j = bus.ex_jump;
    o.jl = bus.ex_jump_link;
    o.jr = bus.ex_jump_reg;
    o.br = bus.ex_branch;
    o.bne = bus.ex_bne;
    o.ill = bus.ex_illegal;
    return o;
  endfunction

  task automatic step();
    bundle_t o, nb;
    logic st, er, acc, is_lw;
    @(negedge clk);
    st = GAP != 0 && bus.in_valid && m_haz > 0
      && reads(bus.in_instr, m_hreg);
    er = reset ? 1'b0 : flush ? 1'b1
       : ((!m_valid || bus.ex_ready) && !st);
    rdy_s = bus.in_ready;
    chk("in_ready", 128'(bus.in_ready), 128'(er));
    chk("ex_valid", 128'(bus.ex_valid), 128'(m_valid));
    if (m_valid) begin
      o = obs();
      if (m_b.ill)
        chk("illegal_ctl",
            128'({o.ill, o.rw, o.mw, o.j, o.jl, o.jr, o.br}),
            128'({m_b.ill, m_b.rw, m_b.mw, m_b.j,
                  m_b.jl, m_b.jr, m_b.br}));
      else
        chk("bundle", 128'(o), 128'(m_b));
    end
    acc = bus.in_valid && er && !flush && !reset;
    nb = ref_decode(bus.in_instr, bus.in_pc);
    is_lw = mnem(bus.in_instr) == "lw";
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0;
      m_b = '0;
      m_haz = 0;
      m_hreg = 0;
    end else if (flush) begin
      m_valid = 0;
      m_haz = 0;
    end else begin
      if (acc) begin
        m_b = nb;
        m_valid = 1;
      end else if (bus.ex_ready) begin
        m_valid = 0;
      end
      if (acc && is_lw && nb.rt != 0) begin
        m_haz = GAP;
        m_hreg = nb.rt;
      end else if (bus.ex_ready && m_haz > 0) begin
        m_haz--;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic rdy,
                       input logic fl, input logic rst);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.ex_ready = rdy;
    flush = fl;
    reset = rst;
    step();
  endtask

  function automatic logic [4:0] rreg();
    case ($urandom % 5)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd8;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [4:0]  a, b, d;
    r = $urandom;
    a = rreg();
    b = rreg();
    d = rreg();
    case ($urandom % 16)
      0, 15: return {6'h23, a, b, r[15:0]};
      1:  return {6'h2b, a, b, r[15:0]};
      2:  return {6'h02, r[25:0]};
      3:  return {6'h03, r[25:0]};
      4:  return {6'h04, a, b, r[15:0]};
      5:  return {6'h05, a, b, r[15:0]};
      6:  return {6'h0e, a, b, r[15:0]};
      7:  return {6'h08, a, b, r[15:0]};
      8:  return {6'h09, a, b, r[15:0]};
      9:  return {6'h00, a, b, d, 5'd0, 6'h20};
      10: return {6'h00, a, b, d, 5'd0, 6'h22};
      11: return {6'h00, a, b, d, 5'd0, 6'h2a};
      12: return {6'h00, a, 15'd0, 6'h08};
      13: return {6'h3f, r[25:0]};
      default: return {6'h00, a, b, d, 5'd0, 6'h21};
    endcase
  endfunction

  initial begin
    bus.in_valid = 0;
    bus.in_instr = 0;
    bus.in_pc = 0;
    bus.ex_ready = 0;
    flush = 0;
    reset = 1;
    m_valid = 0;
    m_b = '0;
    m_haz = 0;
    m_hreg = 0;
    @(posedge clk);
    #1;
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    chk("rst_bundle", 128'(obs()), 128'd0);
    chk("rst_valid", 128'(bus.ex_valid), 128'd0);
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    chk("rst_rdy", 128'(rdy_s), 128'd1);

    drive(1, 32'h0C000010, 32'h100, 1, 0, 0);
    chk("jal_ctl",
        128'({bus.ex_valid, bus.ex_jump, bus.ex_jump_link,
              bus.ex_reg_write}), 128'(4'hF));
    chk("jal_wa", 128'(bus.ex_wa), 128'd31);
    chk("jal_target", 128'(bus.ex_target), 128'h40);
    chk("jal_pc", 128'(bus.ex_pc), 128'h100);

    drive(1, 32'h8E080000, 32'h104, 1, 0, 0);
    chk("lw_issue", 128'(bus.ex_mem_to_reg), 128'd1);
    drive(1, 32'h010A4820, 32'h108, 1, 0, 0);
    chk("lu_stall", 128'(rdy_s), 128'd0);
    chk("lu_bubble", 128'(bus.ex_valid), 128'd0);
    drive(1, 32'h010A4820, 32'h108, 1, 0, 0);
    chk("lu_resume", 128'(rdy_s), 128'd1);
    chk("add_fields",
        128'({bus.ex_valid, bus.ex_alu_op, bus.ex_wa,
              bus.ex_use_rt}),
        128'({1'b1, 3'd0, 5'd9, 1'b1}));

    drive(1, 32'h3908FFFF, 32'h10C, 1, 0, 0);
    chk("xori_imm", 128'(bus.ex_imm), 128'h0000FFFF);
    chk("xori_fields",
        128'({bus.ex_alu_op, bus.ex_wa, bus.ex_use_rt}),
        128'({3'd2, 5'd8, 1'b0}));

    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h21030005, 32'h110, 0, 0, 0);
      chk("hold_rdy", 128'(rdy_s), 128'd0);
      chk("hold_pc", 128'(bus.ex_pc), 128'h10C);
    end
    drive(1, 32'h21030005, 32'h110, 1, 0, 0);
    chk("release_pc", 128'(bus.ex_pc), 128'h110);

    drive(1, 32'h8E080000, 32'h200, 1, 0, 0);
    drive(1, 32'h010A4820, 32'h204, 1, 1, 0);
    chk("flush_rdy", 128'(rdy_s), 128'd1);
    chk("flush_valid", 128'(bus.ex_valid), 128'd0);
    drive(1, 32'h010A4820, 32'h204, 1, 0, 0);
    chk("flush_nostall", 128'(rdy_s), 128'd1);
    chk("flush_add", 128'({bus.ex_valid, bus.ex_wa}),
        128'({1'b1, 5'd9}));

    drive(1, 32'hFC000000, 32'h208, 1, 0, 0);
    chk("illegal",
        128'({bus.ex_illegal, bus.ex_reg_write,
              bus.ex_mem_write}), 128'(3'b100));

    for (int c = 0; c < 4000; c++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      drive($urandom % 4 != 0, rnd_instr(), pc,
            $urandom % 4 != 0, $urandom % 25 == 0,
            $urandom % 400 == 0);
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
